// File: rtl/hitchhike_pkg.sv
// Shared definitions for the backscatter transmit path: frame categories,
// scheduler state encodings and the layout of one scheme slot byte.
package hitchhike_pkg;

  // Frame categories reported by the downlink demodulator
  localparam logic [1:0] CTG_ABORT  = 2'b01;
  localparam logic [1:0] CTG_FLAG   = 2'b10;
  localparam logic [1:0] CTG_SCHEME = 2'b11;

  // Scheduler states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Slot byte layout: {valid, code[2:0], rep[3:0]}; slot 0 sits in scheme[47:40]
  localparam int NUM_SLOTS    = 6;
  localparam int SLOT_VALID   = 7;
  localparam int SLOT_CODE_HI = 6;
  localparam int SLOT_CODE_LO = 4;
  localparam int SLOT_REP_HI  = 3;
  localparam int SLOT_REP_LO  = 0;

  // Byte of slot k; out-of-range k yields an all-zero (invalid) slot
  function automatic logic [7:0] slot_byte(input logic [47:0] scheme, input logic [2:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (k == 3'(i)) b = scheme[(NUM_SLOTS-1-i)*8 +: 8];
    end
    return b;
  endfunction

  // True when at least one slot of the scheme carries its valid bit
  function automatic logic any_valid(input logic [47:0] scheme);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      v = v | scheme[i*8 + SLOT_VALID];
    end
    return v;
  endfunction

  // Repetition field to packet count; zero encodes the maximum of 16
  function automatic logic [4:0] rep_load(input logic [3:0] rep);
    return (rep == 4'd0) ? 5'd16 : {1'b0, rep};
  endfunction

endpackage

// File: rtl/backscatter_scheduler_if.sv
// Demodulator/modulator side signals of the backscatter scheduler.
// master drives frames and tx_done; slave is the scheduler itself.
interface backscatter_scheduler_if;
  logic [1:0]  ord;
  logic [1:0]  ctg;
  logic [7:0]  cur_flag;
  logic [47:0] cur_scheme;
  logic        tx_done;
  logic        working;
  logic        tx_start;
  logic [2:0]  tx_code;
  logic [2:0]  slot_idx;
  logic        sched_err;

  modport master (
    output ord, ctg, cur_flag, cur_scheme, tx_done,
    input  working, tx_start, tx_code, slot_idx, sched_err
  );

  modport slave (
    input  ord, ctg, cur_flag, cur_scheme, tx_done,
    output working, tx_start, tx_code, slot_idx, sched_err
  );
endinterface

// File: rtl/backscatter_slot_sel.sv
// Finds the lowest-numbered valid slot at or above start_idx.
module backscatter_slot_sel
  import hitchhike_pkg::*;
(
  input  logic [47:0] scheme,
  input  logic [2:0]  start_idx,
  output logic        found,
  output logic [2:0]  next_idx
);
  logic [NUM_SLOTS-1:0] valid_vec;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_valid
      assign valid_vec[gi] = scheme[(NUM_SLOTS-1-gi)*8 + SLOT_VALID];
    end
  endgenerate

  // Scan downwards so the last hit written is the lowest qualifying slot
  always_comb begin
    found    = 1'b0;
    next_idx = 3'd0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (valid_vec[i] && (3'(i) >= start_idx)) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
    end
  end
endmodule

// File: rtl/backscatter_scheduler.sv
// Backscatter transmit scheduler: latches a slot scheme from the downlink,
// runs it when a matching flag arrives and gates the demodulator meanwhile.
module backscatter_scheduler
  import hitchhike_pkg::*;
#(
  parameter logic [7:0]  TAG_ID     = 8'h5A,
  parameter logic [15:0] GAP_CYCLES = 16'd50,
  parameter logic [19:0] TX_TIMEOUT = 20'd4095
) (
  input  logic                   clock,
  input  logic                   reset,
  backscatter_scheduler_if.slave bus
);
  logic [2:0]  state_reg, state_next;
  logic [1:0]  ord_q_reg;
  logic [47:0] scheme_reg, scheme_next;
  logic [2:0]  slot_idx_reg, slot_idx_next;
  logic [2:0]  tx_code_reg, tx_code_next;
  logic [4:0]  rep_reg, rep_next;
  logic [19:0] wait_reg, wait_next;
  logic [15:0] gap_reg, gap_next;
  logic        working_reg, tx_start_reg, sched_err_reg, err_next;
  logic        evt, flag_hit, sel_found;
  logic [2:0]  sel_start, sel_idx;
  logic [7:0]  sel_byte;

  // Any change of the frame counter, including the 3->0 wrap, is one new frame
  assign evt      = (bus.ord != ord_q_reg);
  assign flag_hit = (bus.cur_flag == TAG_ID) || (bus.cur_flag == 8'hFF);

  // From ARMED the run begins at the first valid slot; from WAIT look past the current one
  assign sel_start = (state_reg == ST_ARMED) ? 3'd0 : slot_idx_reg + 3'd1;

  backscatter_slot_sel u_slot_sel (
    .scheme    (scheme_reg),
    .start_idx (sel_start),
    .found     (sel_found),
    .next_idx  (sel_idx)
  );

  assign sel_byte = slot_byte(scheme_reg, sel_idx);

  // Next-state and datapath decisions
  always_comb begin
    state_next    = state_reg;
    scheme_next   = scheme_reg;
    slot_idx_next = slot_idx_reg;
    tx_code_next  = tx_code_reg;
    rep_next      = rep_reg;
    wait_next     = wait_reg;
    gap_next      = gap_reg;
    err_next      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ARMED: begin
        if (evt && bus.ctg == CTG_SCHEME) begin
          if (any_valid(bus.cur_scheme)) begin
            scheme_next = bus.cur_scheme;
            state_next  = ST_ARMED;
          end else begin
            scheme_next = '0;
            state_next  = ST_IDLE;
          end
        end else if (state_reg == ST_ARMED && evt && bus.ctg == CTG_ABORT) begin
          scheme_next = '0;
          state_next  = ST_IDLE;
        end else if (state_reg == ST_ARMED && evt && bus.ctg == CTG_FLAG && flag_hit &&
                     sel_found && sel_byte[SLOT_VALID]) begin
          state_next    = ST_START;
          slot_idx_next = sel_idx;
          tx_code_next  = sel_byte[SLOT_CODE_HI:SLOT_CODE_LO];
          rep_next      = rep_load(sel_byte[SLOT_REP_HI:SLOT_REP_LO]);
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
        wait_next  = '0;
      end
      ST_WAIT: begin
        // tx_done takes priority over a coincident timeout
        if (bus.tx_done) begin
          if (rep_reg > 5'd1) begin
            rep_next   = rep_reg - 5'd1;
            state_next = ST_GAP;
            gap_next   = '0;
          end else if (sel_found && sel_byte[SLOT_VALID]) begin
            slot_idx_next = sel_idx;
            tx_code_next  = sel_byte[SLOT_CODE_HI:SLOT_CODE_LO];
            rep_next      = rep_load(sel_byte[SLOT_REP_HI:SLOT_REP_LO]);
            state_next    = ST_GAP;
            gap_next      = '0;
          end else begin
            scheme_next = '0;
            state_next  = ST_IDLE;
          end
        end else if (wait_reg == TX_TIMEOUT) begin
          scheme_next = '0;
          err_next    = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          wait_next = wait_reg + 20'd1;
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_CYCLES - 16'd1) begin
          state_next = ST_START;
        end else begin
          gap_next = gap_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers; pulses and working are derived from the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ord_q_reg     <= 2'd0;
      scheme_reg    <= '0;
      slot_idx_reg  <= 3'd0;
      tx_code_reg   <= 3'd0;
      rep_reg       <= 5'd0;
      wait_reg      <= '0;
      gap_reg       <= '0;
      working_reg   <= 1'b0;
      tx_start_reg  <= 1'b0;
      sched_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ord_q_reg     <= bus.ord;
      scheme_reg    <= scheme_next;
      slot_idx_reg  <= slot_idx_next;
      tx_code_reg   <= tx_code_next;
      rep_reg       <= rep_next;
      wait_reg      <= wait_next;
      gap_reg       <= gap_next;
      working_reg   <= (state_next == ST_START) || (state_next == ST_WAIT) ||
                       (state_next == ST_GAP);
      tx_start_reg  <= (state_next == ST_START);
      sched_err_reg <= err_next;
    end
  end

  assign bus.working   = working_reg;
  assign bus.tx_start  = tx_start_reg;
  assign bus.tx_code   = tx_code_reg;
  assign bus.slot_idx  = slot_idx_reg;
  assign bus.sched_err = sched_err_reg;
endmodule
